wb_port_arbiter: RTL and testbench

Parametrised writeback arbiter between the execute units and the physical register file / commit stage. It accepts up to SRC_NUM completed results per cycle, buffers each source in a small per-source FIFO, and grants up to WB_PORT_NUM results per cycle with rotating priority. Results go to registered physical-register write ports and to the wakeup/commit feedback channels. This replaces the fixed one-port-per-unit writeback when the unit count exceeds the register-file write ports.

---
 rtl/wb_port_arbiter_pkg.sv | 30 +++
 rtl/wb_port_arbiter_if.sv | 41 ++++
 rtl/wb_port_arbiter_src_fifo.sv | 60 ++++++
 rtl/wb_port_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Brief    : Shared types, widths and rotate-priority helper for the
//            writeback port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int c_PHY_ID_W = 6;
    localparam int c_DATA_W   = 32;
    localparam int c_ROB_ID_W = 5;

    typedef struct packed {
        logic [c_PHY_ID_W-1:0] rd_phy;
        logic [c_DATA_W-1:0]   rd_value;
        logic [c_ROB_ID_W-1:0] rob_id;
        logic                  rd_write;
    } wb_arb_entry_t;

    // (base + off) mod n, valid for base < n and off < n
    function automatic int rot_idx(input int base, input int off, input int n);
        int v_sum;
        v_sum = base + off;
        if (v_sum >= n) v_sum = v_sum - n;
        return v_sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_if
// Brief    : Source-side result handshake and writeback port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int SRC_NUM     = 6,
    parameter int WB_PORT_NUM = 4,
    parameter int PHY_ID_W    = c_PHY_ID_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int ROB_ID_W    = c_ROB_ID_W
);
    logic [SRC_NUM-1:0]                 src_valid;
    logic [SRC_NUM-1:0]                 src_ready;
    logic [SRC_NUM-1:0][PHY_ID_W-1:0]   src_rd_phy;
    logic [SRC_NUM-1:0][DATA_W-1:0]     src_rd_value;
    logic [SRC_NUM-1:0][ROB_ID_W-1:0]   src_rob_id;
    logic [SRC_NUM-1:0]                 src_rd_write;

    logic [WB_PORT_NUM-1:0]               wb_valid;
    logic [WB_PORT_NUM-1:0]               wb_phyf_we;
    logic [WB_PORT_NUM-1:0][PHY_ID_W-1:0] wb_phyf_id;
    logic [WB_PORT_NUM-1:0][DATA_W-1:0]   wb_phyf_data;
    logic [WB_PORT_NUM-1:0][ROB_ID_W-1:0] wb_rob_id;

    modport master (
        output src_valid, src_rd_phy, src_rd_value, src_rob_id, src_rd_write,
        input  src_ready,
        input  wb_valid, wb_phyf_we, wb_phyf_id, wb_phyf_data, wb_rob_id
    );

    modport slave (
        input  src_valid, src_rd_phy, src_rd_value, src_rob_id, src_rd_write,
        output src_ready,
        output wb_valid, wb_phyf_we, wb_phyf_id, wb_phyf_data, wb_rob_id
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter_src_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_src_fifo
// Brief    : Single-source circular FIFO with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module wb_src_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_clr;
    logic               w_push;
    logic               w_pop;

    assign w_clr   = rst | i_clr;
    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full & ~w_clr;
    assign w_pop   = i_pop & ~o_empty & ~w_clr;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Buffers execute results per source and grants up to
//            WB_PORT_NUM of them per cycle with rotating priority.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int SRC_NUM     = 6,
    parameter int WB_PORT_NUM = 4,
    parameter int QUEUE_DEPTH = 2,
    parameter int PHY_ID_W    = c_PHY_ID_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int ROB_ID_W    = c_ROB_ID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    wb_port_arbiter_if.slave bus
);
    localparam int c_SRC_W   = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
    localparam int c_ENTRY_W = PHY_ID_W + DATA_W + ROB_ID_W + 1;

    logic [c_ENTRY_W-1:0]   w_push_data [SRC_NUM];
    logic [c_ENTRY_W-1:0]   w_head      [SRC_NUM];
    logic [SRC_NUM-1:0]     w_full;
    logic [SRC_NUM-1:0]     w_empty;
    logic [SRC_NUM-1:0]     w_pop;
    logic [WB_PORT_NUM-1:0] w_port_vld;
    logic [c_SRC_W-1:0]     w_port_src [WB_PORT_NUM];
    logic [c_SRC_W-1:0]     w_last_src;
    logic [c_SRC_W-1:0]     r_rr_ptr;

    for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
        assign w_push_data[i] = {bus.src_rd_phy[i], bus.src_rd_value[i],
                                 bus.src_rob_id[i], bus.src_rd_write[i]};
        assign bus.src_ready[i] = ~w_full[i];

        wb_src_fifo #(
            .DEPTH (QUEUE_DEPTH),
            .WIDTH (c_ENTRY_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_clr   (flush),
            .i_push  (bus.src_valid[i]),
            .i_data  (w_push_data[i]),
            .i_pop   (w_pop[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i]),
            .o_head  (w_head[i])
        );
    end

    // Scan from r_rr_ptr; the n-th non-empty source found goes to port n
    always_comb begin
        int                 v_rank;
        logic [c_SRC_W-1:0] v_idx;
        w_port_vld = '0;
        w_pop      = '0;
        w_last_src = r_rr_ptr;
        v_rank     = 0;
        v_idx      = '0;
        for (int p = 0; p < WB_PORT_NUM; p++) w_port_src[p] = '0;
        for (int k = 0; k < SRC_NUM; k++) begin
            v_idx = c_SRC_W'(rot_idx(int'(r_rr_ptr), k, SRC_NUM));
            if (!w_empty[v_idx]) begin
                for (int p = 0; p < WB_PORT_NUM; p++) begin
                    if (v_rank == p) begin
                        w_port_vld[p] = 1'b1;
                        w_port_src[p] = v_idx;
                        w_pop[v_idx]  = 1'b1;
                        w_last_src    = v_idx;
                    end
                end
                v_rank = v_rank + 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rr_ptr <= '0;
        end else if (|w_port_vld) begin
            r_rr_ptr <= c_SRC_W'(rot_idx(int'(w_last_src), 1, SRC_NUM));
        end
    end

    for (genvar p = 0; p < WB_PORT_NUM; p++) begin : g_port
        logic [c_ENTRY_W-1:0] w_sel;
        logic                 r_valid;
        logic                 r_we;
        logic [PHY_ID_W-1:0]  r_id;
        logic [DATA_W-1:0]    r_data;
        logic [ROB_ID_W-1:0]  r_rob;

        assign w_sel = w_head[w_port_src[p]];

        // Payload fields hold while the port is idle
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_valid <= 1'b0;
                r_we    <= 1'b0;
                r_id    <= '0;
                r_data  <= '0;
                r_rob   <= '0;
            end else if (w_port_vld[p]) begin
                r_valid <= 1'b1;
                r_we    <= w_sel[0];
                r_id    <= w_sel[c_ENTRY_W-1 -: PHY_ID_W];
                r_data  <= w_sel[ROB_ID_W+DATA_W -: DATA_W];
                r_rob   <= w_sel[ROB_ID_W:1];
            end else begin
                r_valid <= 1'b0;
                r_we    <= 1'b0;
            end
        end

        assign bus.wb_valid[p]     = r_valid;
        assign bus.wb_phyf_we[p]   = r_we;
        assign bus.wb_phyf_id[p]   = r_id;
        assign bus.wb_phyf_data[p] = r_data;
        assign bus.wb_rob_id[p]    = r_rob;
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Directed vector table plus corner sequences for the arbiter,
//            and a scoreboarded 3-source / 1-port configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush_a;
    logic flush_b;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.SRC_NUM(6), .WB_PORT_NUM(4)) bus_a ();
    wb_port_arbiter_if #(.SRC_NUM(3), .WB_PORT_NUM(1)) bus_b ();

    wb_port_arbiter #(.SRC_NUM(6), .WB_PORT_NUM(4), .QUEUE_DEPTH(2)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_a),
        .bus   (bus_a.slave)
    );

    wb_port_arbiter #(.SRC_NUM(3), .WB_PORT_NUM(1), .QUEUE_DEPTH(4)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_b),
        .bus   (bus_b.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] mk_phy(input logic [4:0] rob);
        return 6'(rob) + 6'd7;
    endfunction

    function automatic logic [31:0] mk_data(input logic [4:0] rob);
        return 32'hA500_0000 | ({27'd0, rob} * 32'h0001_0001);
    endfunction

    task automatic drive_a(input logic [5:0] push, input logic [4:0] base);
        for (int i = 0; i < 6; i++) begin
            logic [4:0] r;
            r = base + 5'(i);
            bus_a.src_valid[i]    = push[i];
            bus_a.src_rob_id[i]   = r;
            bus_a.src_rd_phy[i]   = mk_phy(r);
            bus_a.src_rd_value[i] = mk_data(r);
            bus_a.src_rd_write[i] = ~r[0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One row: pushes before the edge, expected outputs after it
    typedef struct packed {
        logic [5:0]      push;
        logic [4:0]      base;
        logic [3:0]      exp_valid;
        logic [5:0]      exp_ready;
        logic [3:0][4:0] exp_rob;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] push, input logic [4:0] base, input logic [3:0] v,
                       input logic [5:0] rdy, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] r3);
        vec_t e;
        e.push      = push;
        e.base      = base;
        e.exp_valid = v;
        e.exp_ready = rdy;
        e.exp_rob   = {r3, r2, r1, r0};
        tbl.push_back(e);
    endtask

    logic [43:0] sbq [3][$];
    int          seq_b [3];
    int          wait_b [3];
    int          max_w [3];

    initial begin
        rst     = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        drive_a(6'h00, 5'd0);
        bus_b.src_valid    = '0;
        bus_b.src_rd_phy   = '0;
        bus_b.src_rd_value = '0;
        bus_b.src_rob_id   = '0;
        bus_b.src_rd_write = '0;

        //    push      base  valid    ready      r0 r1 r2 r3
        add(6'h3F,      0, 4'b0000, 6'h3F,      0, 0, 0, 0);
        add(6'h00,      0, 4'b1111, 6'h3F,      0, 1, 2, 3);
        add(6'h00,      0, 4'b0011, 6'h3F,      4, 5, 0, 0);
        add(6'h00,      0, 4'b0000, 6'h3F,      0, 0, 0, 0);
        add(6'b000100, 10, 4'b0000, 6'h3F,      0, 0, 0, 0);
        add(6'h00,      0, 4'b0001, 6'h3F,     12, 0, 0, 0);
        add(6'h00,      0, 4'b0000, 6'h3F,      0, 0, 0, 0);
        add(6'b100011, 20, 4'b0000, 6'h3F,      0, 0, 0, 0);
        add(6'h00,      0, 4'b0111, 6'h3F,     25, 20, 21, 0);
        add(6'h00,      0, 4'b0000, 6'h3F,      0, 0, 0, 0);
        add(6'h3F,      0, 4'b0000, 6'h3F,      0, 0, 0, 0);
        add(6'h3F,      6, 4'b1111, 6'b111100,  2, 3, 4, 5);
        add(6'h3F,     12, 4'b1111, 6'b001111,  0, 1, 8, 9);
        add(6'h00,      0, 4'b1111, 6'h3F,     10, 11, 6, 7);
        add(6'h00,      0, 4'b1111, 6'h3F,     14, 15, 16, 17);
        add(6'h00,      0, 4'b0000, 6'h3F,      0, 0, 0, 0);

        tick();
        tick();
        rst = 1'b0;

        check("reset valid", bus_a.wb_valid, 0);
        check("reset we", bus_a.wb_phyf_we, 0);
        check("reset id", bus_a.wb_phyf_id, 0);
        check("reset data", bus_a.wb_phyf_data[0], 0);
        check("reset rob", bus_a.wb_rob_id, 0);
        check("reset ready", bus_a.src_ready, 6'h3F);

        for (int k = 0; k < tbl.size(); k++) begin
            logic [3:0] exp_we;
            drive_a(tbl[k].push, tbl[k].base);
            tick();
            for (int p = 0; p < 4; p++) exp_we[p] = tbl[k].exp_valid[p] & ~tbl[k].exp_rob[p][0];
            check($sformatf("v%0d valid", k), bus_a.wb_valid, tbl[k].exp_valid);
            check($sformatf("v%0d we", k), bus_a.wb_phyf_we, exp_we);
            check($sformatf("v%0d ready", k), bus_a.src_ready, tbl[k].exp_ready);
            for (int p = 0; p < 4; p++) begin
                if (tbl[k].exp_valid[p]) begin
                    check($sformatf("v%0d p%0d rob", k, p), bus_a.wb_rob_id[p], tbl[k].exp_rob[p]);
                    check($sformatf("v%0d p%0d id", k, p), bus_a.wb_phyf_id[p], mk_phy(tbl[k].exp_rob[p]));
                    check($sformatf("v%0d p%0d data", k, p), bus_a.wb_phyf_data[p], mk_data(tbl[k].exp_rob[p]));
                end
            end
        end

        // Single push: two-cycle latency, then idle
        drive_a(6'h00, 5'd0);
        bus_a.src_valid[2]    = 1'b1;
        bus_a.src_rd_phy[2]   = 6'd9;
        bus_a.src_rd_value[2] = 32'hDEADBEEF;
        bus_a.src_rob_id[2]   = 5'd3;
        bus_a.src_rd_write[2] = 1'b1;
        tick();
        bus_a.src_valid = '0;
        check("single c1 valid", bus_a.wb_valid, 0);
        tick();
        check("single valid", bus_a.wb_valid, 4'b0001);
        check("single we", bus_a.wb_phyf_we, 4'b0001);
        check("single id", bus_a.wb_phyf_id[0], 6'd9);
        check("single data", bus_a.wb_phyf_data[0], 32'hDEADBEEF);
        check("single rob", bus_a.wb_rob_id[0], 5'd3);
        tick();
        check("single c3 valid", bus_a.wb_valid, 0);

        // Result without register write still reports completion
        bus_a.src_valid[4]    = 1'b1;
        bus_a.src_rd_phy[4]   = 6'd33;
        bus_a.src_rd_value[4] = 32'h0000_1234;
        bus_a.src_rob_id[4]   = 5'd17;
        bus_a.src_rd_write[4] = 1'b0;
        tick();
        bus_a.src_valid = '0;
        tick();
        check("nowrite valid", bus_a.wb_valid, 4'b0001);
        check("nowrite we", bus_a.wb_phyf_we, 4'b0000);
        check("nowrite rob", bus_a.wb_rob_id[0], 5'd17);

        // Flush with entries queued and outputs live
        drive_a(6'b001111, 5'd0);
        tick();
        drive_a(6'b001111, 5'd8);
        tick();
        check("preflush valid", bus_a.wb_valid, 4'b1111);
        drive_a(6'b000010, 5'd20);
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        drive_a(6'h00, 5'd0);
        check("flush valid", bus_a.wb_valid, 0);
        check("flush we", bus_a.wb_phyf_we, 0);
        check("flush id", bus_a.wb_phyf_id, 0);
        check("flush data", bus_a.wb_phyf_data, 0);
        check("flush rob", bus_a.wb_rob_id, 0);
        check("flush ready", bus_a.src_ready, 6'h3F);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("postflush c%0d valid", c), bus_a.wb_valid, 0);
        end

        // Backpressure: every source pushes every cycle; src 0 order tracked
        pulse_reset();
        begin
            int  seq [6];
            int  exp0;
            logic saw_full;
            exp0     = 0;
            saw_full = 1'b0;
            for (int i = 0; i < 6; i++) seq[i] = 0;
            for (int c = 0; c < 32; c++) begin
                for (int p = 0; p < 4; p++) begin
                    if (bus_a.wb_valid[p] && bus_a.wb_phyf_id[p][5:3] == 3'd0) begin
                        check($sformatf("bp rob c%0d", c), bus_a.wb_rob_id[p], 5'(exp0));
                        exp0++;
                    end
                end
                if (!bus_a.src_ready[0]) saw_full = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    bus_a.src_valid[i]    = (c < 20);
                    bus_a.src_rd_phy[i]   = {3'(i), 3'(seq[i])};
                    bus_a.src_rob_id[i]   = 5'(seq[i]);
                    bus_a.src_rd_value[i] = 32'(seq[i]);
                    bus_a.src_rd_write[i] = 1'b1;
                    if (c < 20 && bus_a.src_ready[i]) seq[i]++;
                end
                tick();
            end
            check("bp ready drop", saw_full, 1'b1);
            check("bp count", 64'(exp0), 64'(seq[0]));
        end

        // Sweep: 3 sources, 1 port, depth 4, random pushes vs scoreboard
        pulse_reset();
        for (int s = 0; s < 3; s++) begin
            seq_b[s]  = 0;
            wait_b[s] = 0;
            max_w[s]  = 0;
        end
        for (int c = 0; c < 320; c++) begin
            int out_s;
            out_s = -1;
            if (bus_b.wb_valid[0]) begin
                logic [43:0] got;
                logic [43:0] exp;
                out_s = int'(bus_b.wb_phyf_id[0][5:4]);
                got = {bus_b.wb_phyf_we[0], bus_b.wb_phyf_id[0], bus_b.wb_phyf_data[0], bus_b.wb_rob_id[0]};
                if (out_s < 3 && sbq[out_s].size() > 0) begin
                    exp = sbq[out_s].pop_front();
                    check($sformatf("sweep c%0d entry", c), got, exp);
                end else begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sweep c%0d unexpected: got %0h required none", c, got);
                end
            end
            for (int s = 0; s < 3; s++) begin
                if (out_s == s) wait_b[s] = 0;
                else if (sbq[s].size() > 0) wait_b[s]++;
                if (wait_b[s] > max_w[s]) max_w[s] = wait_b[s];
            end
            for (int s = 0; s < 3; s++) begin
                logic v;
                v = (c < 300) && ($urandom_range(0, 99) < 60);
                bus_b.src_valid[s]    = v;
                bus_b.src_rd_phy[s]   = {2'(s), 4'(seq_b[s])};
                bus_b.src_rd_value[s] = $urandom;
                bus_b.src_rob_id[s]   = 5'(seq_b[s]);
                bus_b.src_rd_write[s] = 1'($urandom_range(0, 1));
                if (v && bus_b.src_ready[s]) begin
                    sbq[s].push_back({bus_b.src_rd_write[s], bus_b.src_rd_phy[s],
                                      bus_b.src_rd_value[s], bus_b.src_rob_id[s]});
                    seq_b[s]++;
                end
            end
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            check($sformatf("sweep src%0d drained", s), 64'(sbq[s].size()), 0);
            check($sformatf("sweep src%0d wait<=3 (max %0d)", s, max_w[s]), 64'(max_w[s] <= 3), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
